// File: rtl/bp_update_queue_pkg.sv
// Shared branch-predictor types: PHT update packet, two-bit counter states,
// per-branch prediction metadata and the direction-choice helper used by fetch.
package bp_update_queue_pkg;

   localparam int GHR_W = 10;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } TwoBitState;

   typedef struct packed {
      logic        PC_Vaild;
      logic [31:0] Update_PC;
      logic        PC_Taken;
      logic        PC_MissPredict;
   } Update_PHT_S;

   typedef struct packed {
      logic [31:0]      pc;
      logic [1:0]       tbt_cnt;
      logic [1:0]       ghr_cnt;
      logic [1:0]       cpht;
      logic [GHR_W-1:0] ghr;
      logic [GHR_W-1:0] recover_ghr;
   } BP_Meta_S;

   // Chooser MSB selects the two-bit table, otherwise the history-indexed table.
   function automatic logic pred_dir(input logic [1:0] cpht,
                                     input logic [1:0] tbt_cnt,
                                     input logic [1:0] ghr_cnt);
      return cpht[1] ? tbt_cnt[1] : ghr_cnt[1];
   endfunction

endpackage

// File: rtl/bp_update_queue_if.sv
// Fetch/backend-facing bundle of the predictor update queue.
interface bp_update_queue_if #(
   parameter int DEPTH = 8,
   parameter int GHR_W = bp_update_queue_pkg::GHR_W
);
   import bp_update_queue_pkg::*;

   logic                     enq_valid;
   logic                     enq_ready;
   logic [31:0]              enq_pc;
   logic [1:0]               enq_tbt_cnt;
   logic [1:0]               enq_ghr_cnt;
   logic [1:0]               enq_cpht;
   logic [GHR_W-1:0]         enq_ghr;
   logic [GHR_W-1:0]         enq_recover_ghr;
   logic                     res_valid;
   logic [31:0]              res_pc;
   logic                     res_taken;
   logic                     flush;
   logic                     upd_valid;
   logic [31:0]              upd_pc;
   logic                     upd_taken;
   logic                     upd_mispredict;
   logic [1:0]               upd_tbt_cnt;
   logic [1:0]               upd_ghr_cnt;
   logic [1:0]               upd_cpht;
   logic [GHR_W-1:0]         upd_ghr;
   logic [GHR_W-1:0]         upd_recover_ghr;
   logic                     redirect;
   logic                     res_err;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output enq_valid, enq_pc, enq_tbt_cnt, enq_ghr_cnt, enq_cpht, enq_ghr,
             enq_recover_ghr, res_valid, res_pc, res_taken, flush,
      input  enq_ready, upd_valid, upd_pc, upd_taken, upd_mispredict,
             upd_tbt_cnt, upd_ghr_cnt, upd_cpht, upd_ghr, upd_recover_ghr,
             redirect, res_err, count
   );

   modport slave (
      input  enq_valid, enq_pc, enq_tbt_cnt, enq_ghr_cnt, enq_cpht, enq_ghr,
             enq_recover_ghr, res_valid, res_pc, res_taken, flush,
      output enq_ready, upd_valid, upd_pc, upd_taken, upd_mispredict,
             upd_tbt_cnt, upd_ghr_cnt, upd_cpht, upd_ghr, upd_recover_ghr,
             redirect, res_err, count
   );

endinterface

// File: rtl/bp_meta_fifo.sv
// Circular metadata buffer with wrap-bit pointers, a clear and a
// truncate-to-head port that drops every entry younger than the popped head.
module bp_meta_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 58
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   input  logic                   truncate,
   input  logic                   clear,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   import bp_update_queue_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic [AW:0]  rptr_nxt;

   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count    = wptr - rptr;
   assign rdata    = mem[rptr[AW-1:0]];
   assign rptr_nxt = rptr + {{AW{1'b0}}, pop};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         rptr <= rptr_nxt;
         // Truncation wins over a push: anything behind the head is wrong-path.
         if (truncate)
            wptr <= rptr_nxt;
         else if (push)
            wptr <= wptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear && !truncate)
         mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/bp_update_queue.sv
// In-order prediction-metadata queue; on resolve of the head it issues a
// registered PHT/TwoBit/GHR update packet and flags redirect or protocol errors.
module bp_update_queue #(
   parameter int DEPTH = 8,
   parameter int GHR_W = bp_update_queue_pkg::GHR_W
) (
   input  logic              clk,
   input  logic              reset,
   bp_update_queue_if.slave  bus
);
   import bp_update_queue_pkg::*;

   localparam int META_W = 38 + 2 * GHR_W;

   logic [META_W-1:0]      enq_meta;
   logic [META_W-1:0]      head_meta;
   logic                   full;
   logic                   empty;
   logic [$clog2(DEPTH):0] count;
   logic [31:0]            head_pc;
   logic [1:0]             head_tbt, head_gcnt, head_cpht;
   logic [GHR_W-1:0]       head_ghr, head_rghr;
   logic                   res_hit, mis, push, res_err_n;

   logic                   upd_valid_p1, upd_taken_p1, upd_mis_p1;
   logic                   redirect_p1, res_err_p1;
   logic [31:0]            upd_pc_p1;
   logic [1:0]             upd_tbt_p1, upd_gcnt_p1, upd_cpht_p1;
   logic [GHR_W-1:0]       upd_ghr_p1, upd_rghr_p1;

   assign enq_meta = {bus.enq_pc, bus.enq_tbt_cnt, bus.enq_ghr_cnt, bus.enq_cpht,
                      bus.enq_ghr, bus.enq_recover_ghr};
   assign {head_pc, head_tbt, head_gcnt, head_cpht, head_ghr, head_rghr} = head_meta;

   assign res_hit   = bus.res_valid && !empty;
   assign mis       = res_hit && (pred_dir(head_cpht, head_tbt, head_gcnt) != bus.res_taken);
   assign res_err_n = bus.res_valid && (empty || (bus.res_pc != head_pc));
   // A correct resolve frees a slot, so a push is accepted even when full.
   assign push      = bus.enq_valid && !bus.flush && !mis && (!full || res_hit);

   bp_meta_fifo #(.DEPTH(DEPTH), .W(META_W)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .wdata    (enq_meta),
      .pop      (res_hit),
      .truncate (mis),
      .clear    (bus.flush),
      .rdata    (head_meta),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   // Stage p1: registered update packet
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         upd_valid_p1 <= 1'b0;
         upd_taken_p1 <= 1'b0;
         upd_mis_p1   <= 1'b0;
         redirect_p1  <= 1'b0;
         res_err_p1   <= 1'b0;
         upd_pc_p1    <= '0;
         upd_tbt_p1   <= '0;
         upd_gcnt_p1  <= '0;
         upd_cpht_p1  <= '0;
         upd_ghr_p1   <= '0;
         upd_rghr_p1  <= '0;
      end else begin
         upd_valid_p1 <= res_hit;
         redirect_p1  <= mis && !bus.flush;
         res_err_p1   <= res_err_n;
         if (res_hit) begin
            upd_taken_p1 <= bus.res_taken;
            upd_mis_p1   <= mis;
            upd_pc_p1    <= head_pc;
            upd_tbt_p1   <= head_tbt;
            upd_gcnt_p1  <= head_gcnt;
            upd_cpht_p1  <= head_cpht;
            upd_ghr_p1   <= head_ghr;
            upd_rghr_p1  <= head_rghr;
         end
      end
   end

   assign bus.enq_ready       = !full;
   assign bus.count           = count;
   assign bus.upd_valid       = upd_valid_p1;
   assign bus.upd_pc          = upd_pc_p1;
   assign bus.upd_taken       = upd_taken_p1;
   assign bus.upd_mispredict  = upd_mis_p1;
   assign bus.upd_tbt_cnt     = upd_tbt_p1;
   assign bus.upd_ghr_cnt     = upd_gcnt_p1;
   assign bus.upd_cpht        = upd_cpht_p1;
   assign bus.upd_ghr         = upd_ghr_p1;
   assign bus.upd_recover_ghr = upd_rghr_p1;
   assign bus.redirect        = redirect_p1;
   assign bus.res_err         = res_err_p1;

endmodule

// File: tb/tb_bp_update_queue.sv
// Randomized and directed bench for bp_update_queue against a queue-based model.
module tb_bp_update_queue;
   localparam int DEPTH = 8;
   localparam int GHR_W = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bp_update_queue_if #(.DEPTH(DEPTH), .GHR_W(GHR_W)) bus ();

   bp_update_queue #(.DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0]      pc;
      logic [1:0]       tbt, gc, cp;
      logic [GHR_W-1:0] ghr, rghr;
   } ent_t;

   ent_t q[$];
   int   n_checks = 0;
   int   n_err = 0;

   logic             e_valid, e_taken, e_mis, e_redirect, e_err;
   logic [31:0]      e_pc;
   logic [1:0]       e_tbt, e_gc, e_cp;
   logic [GHR_W-1:0] e_ghr, e_rghr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_exp();
      {e_valid, e_taken, e_mis, e_redirect, e_err} = '0;
      e_pc = '0; e_tbt = '0; e_gc = '0; e_cp = '0; e_ghr = '0; e_rghr = '0;
   endtask

   task automatic idle();
      bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_tbt_cnt = '0;
      bus.enq_ghr_cnt = '0; bus.enq_cpht = '0; bus.enq_ghr = '0;
      bus.enq_recover_ghr = '0; bus.res_valid = 1'b0; bus.res_pc = '0;
      bus.res_taken = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic set_enq(input logic [31:0] pc, input logic [1:0] tbt,
                          input logic [1:0] gc, input logic [1:0] cp);
      bus.enq_valid = 1'b1; bus.enq_pc = pc; bus.enq_tbt_cnt = tbt;
      bus.enq_ghr_cnt = gc; bus.enq_cpht = cp;
      bus.enq_ghr = GHR_W'($urandom); bus.enq_recover_ghr = GHR_W'($urandom);
   endtask

   task automatic set_res(input logic [31:0] pc, input logic taken);
      bus.res_valid = 1'b1; bus.res_pc = pc; bus.res_taken = taken;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".upd_valid"}, 64'(bus.upd_valid), 64'(e_valid));
      chk({tag, ".redirect"},  64'(bus.redirect),  64'(e_redirect));
      chk({tag, ".res_err"},   64'(bus.res_err),   64'(e_err));
      chk({tag, ".count"},     64'(bus.count),     64'(q.size()));
      chk({tag, ".upd_pkt"},
          64'({bus.upd_pc, bus.upd_taken, bus.upd_mispredict, bus.upd_tbt_cnt,
               bus.upd_ghr_cnt, bus.upd_cpht, bus.upd_ghr, bus.upd_recover_ghr}),
          64'({e_pc, e_taken, e_mis, e_tbt, e_gc, e_cp, e_ghr, e_rghr}));
   endtask

   // One clock: model the cycle from the driven inputs, clock, then compare.
   task automatic cycle(input string tag);
      logic hit, mis, pred, can_push;
      ent_t h, n;
      #1;
      chk({tag, ".enq_ready"}, 64'(bus.enq_ready), 64'(q.size() < DEPTH));
      hit = bus.res_valid && (q.size() > 0);
      mis = 1'b0;
      e_err = bus.res_valid && ((q.size() == 0) || (bus.res_pc != q[0].pc));
      if (hit) begin
         h = q[0];
         pred = h.cp[1] ? h.tbt[1] : h.gc[1];
         mis = (pred != bus.res_taken);
         e_pc = h.pc; e_tbt = h.tbt; e_gc = h.gc; e_cp = h.cp;
         e_ghr = h.ghr; e_rghr = h.rghr; e_taken = bus.res_taken; e_mis = mis;
      end
      e_valid = hit;
      e_redirect = mis && !bus.flush;
      can_push = bus.enq_valid && !bus.flush && !mis && ((q.size() < DEPTH) || hit);
      n.pc = bus.enq_pc; n.tbt = bus.enq_tbt_cnt; n.gc = bus.enq_ghr_cnt;
      n.cp = bus.enq_cpht; n.ghr = bus.enq_ghr; n.rghr = bus.enq_recover_ghr;
      if (bus.flush) q.delete();
      else begin
         if (hit) begin
            void'(q.pop_front());
            if (mis) q.delete();
         end
         if (can_push) q.push_back(n);
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
      idle();
   endtask

   task automatic enq_one(input logic [31:0] pc, input logic [1:0] tbt,
                          input logic [1:0] gc, input logic [1:0] cp);
      set_enq(pc, tbt, gc, cp);
      cycle("enq");
   endtask

   task automatic drain();
      while (q.size() > 0) begin
         set_res(q[0].pc, q[0].cp[1] ? q[0].tbt[1] : q[0].gc[1]);
         cycle("drain");
      end
   endtask

   initial begin
      logic [31:0] hp;
      logic        ht;
      idle();
      clear_exp();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      chk("reset.enq_ready", 64'(bus.enq_ready), 64'd1);
      reset = 1'b0;

      // Basic resolve, correct prediction
      enq_one(32'h1000, 2'd3, 2'd0, 2'd3);
      enq_one(32'h1004, 2'd3, 2'd0, 2'd3);
      enq_one(32'h1008, 2'd3, 2'd0, 2'd3);
      set_res(32'h1000, 1'b1);
      cycle("basic");
      chk("basic.pc", 64'(bus.upd_pc), 64'h1000);
      drain();

      // Full queue, extra push ignored, then push+pop while full
      for (int i = 0; i < DEPTH; i++) enq_one(32'h2000 + 32'(4 * i), 2'd3, 2'd0, 2'd3);
      enq_one(32'hdead0, 2'd3, 2'd0, 2'd3);
      chk("full.count", 64'(bus.count), 64'd8);
      set_res(32'h2000, 1'b1);
      set_enq(32'h3000, 2'd3, 2'd0, 2'd3);
      cycle("fullpp");
      chk("fullpp.count", 64'(bus.count), 64'd8);
      chk("fullpp.tail", 64'(q[DEPTH-1].pc), 64'h3000);
      drain();

      // Misprediction with dropped same-cycle enqueue
      enq_one(32'h1000, 2'd0, 2'd1, 2'd0);
      for (int i = 1; i < 4; i++) enq_one(32'h1000 + 32'(4 * i), 2'd3, 2'd3, 2'd3);
      set_res(32'h1000, 1'b1);
      set_enq(32'h5000, 2'd3, 2'd3, 2'd3);
      cycle("mis");
      chk("mis.redirect", 64'(bus.redirect), 64'd1);
      chk("mis.count", 64'(bus.count), 64'd0);

      // Error cases
      set_res(32'h1000, 1'b1);
      cycle("emptyres");
      enq_one(32'h1000, 2'd3, 2'd0, 2'd3);
      set_res(32'h2000, 1'b1);
      cycle("pcmis");
      chk("pcmis.err", 64'(bus.res_err), 64'd1);

      // Flush with a same-cycle resolve
      for (int i = 0; i < 5; i++) enq_one(32'h4000 + 32'(4 * i), 2'd3, 2'd0, 2'd3);
      set_res(32'h4000, 1'b0);
      bus.flush = 1'b1;
      set_enq(32'h6000, 2'd3, 2'd0, 2'd3);
      cycle("flush");

      // Asynchronous reset mid-stream
      for (int i = 0; i < 7; i++) enq_one(32'h7000 + 32'(4 * i), 2'd3, 2'd0, 2'd3);
      set_res(32'h7000, 1'b1);
      cycle("prearst");
      #2;
      reset = 1'b1;
      #1;
      q.delete();
      clear_exp();
      check_outputs("arst");
      chk("arst.enq_ready", 64'(bus.enq_ready), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Pointer wrap: steady push+pop
      for (int i = 0; i < 3; i++) enq_one(32'h8000 + 32'(4 * i), 2'd3, 2'd0, 2'd3);
      for (int i = 3; i < 23; i++) begin
         set_res(q[0].pc, 1'b1);
         set_enq(32'h8000 + 32'(4 * i), 2'd3, 2'd0, 2'd3);
         cycle("wrap");
      end
      drain();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(2) != 0)
            set_enq({$urandom_range(16'hffff), 16'h0}, 2'($urandom), 2'($urandom), 2'($urandom));
         if ($urandom_range(1) == 1) begin
            hp = (q.size() > 0 && $urandom_range(9) != 0) ? q[0].pc : $urandom;
            ht = (q.size() > 0) ? (q[0].cp[1] ? q[0].tbt[1] : q[0].gc[1]) : 1'($urandom);
            if ($urandom_range(4) == 0) ht = ~ht;
            set_res(hp, ht);
         end
         bus.flush = ($urandom_range(29) == 0);
         cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- In-order queue of prediction metadata between fetch and branch resolution.
- Fetch pushes the PHT prediction snapshot for each predicted branch.
- When the backend resolves the oldest branch, the block computes the chosen direction and misprediction, then emits one registered update packet to the PHT, TwoBit and GlobalHistory update ports.
- It is the writer side of the predictor update interface; the PHT is the reader.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 2.
- GHR_W, 10, global history width, matching the GlobalHistory block.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- enq_valid  in  1  fetch pushes a predicted branch
- enq_ready  out  1  queue not full
- enq_pc  in  32  branch PC
- enq_tbt_cnt  in  2  TBT counter at predict time
- enq_ghr_cnt  in  2  GHR counter at predict time
- enq_cpht  in  2  chooser counter at predict time
- enq_ghr  in  GHR_W  speculative GHR at predict time
- enq_recover_ghr  in  GHR_W  GHR checkpoint used for recovery
- res_valid  in  1  backend resolves the oldest branch
- res_pc  in  32  PC of the resolved branch
- res_taken  in  1  actual direction
- flush  in  1  pipeline-wide flush (exception/eret); discards all entries
- upd_valid  out  1  update packet valid (maps to Update_PHT.PC_Vaild)
- upd_pc  out  32  Update_PC
- upd_taken  out  1  PC_Taken
- upd_mispredict  out  1  PC_MissPredict
- upd_tbt_cnt, upd_ghr_cnt, upd_cpht  out  2 each  stored counters
- upd_ghr, upd_recover_ghr  out  GHR_W each  stored history
- redirect  out  1  one-cycle pulse on a misprediction
- res_err  out  1  one-cycle pulse on resolve with an empty queue or a PC mismatch
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage is a circular buffer. Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - Full: pointer MSBs differ and the remaining bits are equal.
  - Empty: pointers are equal.
- enq_ready equals not full, computed combinationally. An enqueue fires when enq_valid && enq_ready. enq_valid while full is ignored; no entry is written and nothing is corrupted.
- Resolve acts on the head entry only.
  - Predicted direction: if cpht[1] is 1, use tbt_cnt[1]; otherwise use ghr_cnt[1].
  - mispredict = predicted direction != res_taken.
- Update packet is registered with 1-cycle latency.
  - The cycle after a resolve: upd_valid=1 and all fields come from the head entry, with upd_taken=res_taken.
  - Otherwise upd_valid=0 and the other upd_* fields hold their last values.
- Resolve on an empty queue: no update, res_err pulses, and the pointers do not change.
- res_pc != head pc:
  - Update still issues from the head entry.
  - res_err pulses.
  - The entry pops.
- On a misprediction:
  - The head pops.
  - The write pointer is set to the new read pointer, so all younger wrong-path entries are discarded.
  - redirect pulses in the same cycle as upd_valid.
- A simultaneous enqueue in the misprediction cycle is dropped (it is wrong-path).
- A simultaneous enqueue and correct-prediction resolve both take effect; count is unchanged. This is legal while full, because the pop frees a slot; enq_ready, however, still reflects full in that cycle.
- flush has the highest priority:
  - Both pointers go to 0.
  - Any same-cycle enqueue is dropped.
  - A same-cycle resolve is still reported (upd_valid next cycle), since that branch is retired.
  - redirect is not asserted by flush.
- Reset (asynchronous, any time, including mid-operation):
  - Pointers = 0, count = 0, enq_ready = 1 after assertion.
  - All upd_* = 0, redirect = 0, res_err = 0.
  - Entry RAM contents are don't-care.
- count = wptr - rptr, computed modulo 2^($clog2(DEPTH)+1).

Decomposition:
- Shared package (the one already holding Update_PHT_S and TwoBitState) gains:
  - BP_Meta_S typedef: pc, tbt_cnt, ghr_cnt, cpht, ghr, recover_ghr.
  - GHR_W constant.
  - Function pred_dir(cpht, tbt_cnt, ghr_cnt), shared with fetch.
- One natural sub-module, bp_meta_fifo: circular-buffer storage and pointers with a truncate-to-head port. The top level adds resolve logic, error detection and output registers.

Test Plan:
- Reset, enqueue 3 entries (pc 0x1000/0x1004/0x1008, cpht=3, tbt=3), resolve 0x1000 with taken=1 -> next cycle upd_valid=1, upd_pc=0x1000, upd_mispredict=0, redirect=0; count=2.
- Fill DEPTH=8 entries, enq_valid one more -> enq_ready=0, count=8, write ignored. Then resolve plus enqueue in the same cycle -> count stays 8; the oldest pc pops and the new pc is at the tail.
- 4 entries, head cpht=0, ghr_cnt=1, res_taken=1 -> upd_mispredict=1, redirect pulses, count=0 next cycle; an enqueue in the same cycle is dropped.
- Resolve while empty -> res_err=1 for one cycle, upd_valid=0, count=0. Resolve with res_pc=0x2000 vs head 0x1000 -> res_err=1, update uses pc 0x1000.
- flush with 5 entries plus a same-cycle resolve -> update issued for the head, count=0, redirect=0.
- Assert reset asynchronously mid-stream with count=6 and upd_valid=1 -> outputs clear before the next clk edge; enq_ready=1.
- Run 20 wrap cycles of enqueue/resolve -> pointer wrap gives the correct pc order.
